// File: rtl/step_pulse_sequencer.sv
// rtl/step_pulse_sequencer.sv - signed step accumulator driving a timed step/dir pulse FSM
// Optional macro STEP_POSITION_COUNTER_EN adds a 32-bit signed position output.
module step_pulse_sequencer #(
    parameter int deltaBits       = 16,
    parameter int pendingBits     = 20,
    parameter int pulseHighCycles = 250,
    parameter int pulseLowCycles  = 250,
    parameter int dirSetupCycles  = 100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   delta_valid,
    input  logic [deltaBits-1:0]   delta_steps,
    input  logic                   flush,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   overflow,
    output logic [pendingBits-1:0] pending
`ifdef STEP_POSITION_COUNTER_EN
    ,
    output logic [31:0]            position
`endif
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_DIR_SETUP  = 2'd1;
    localparam logic [1:0] S_PULSE_HIGH = 2'd2;
    localparam logic [1:0] S_PULSE_LOW  = 2'd3;

    localparam int MAX_HL = (pulseHighCycles > pulseLowCycles) ? pulseHighCycles : pulseLowCycles;
    localparam int MAX_C  = (MAX_HL > dirSetupCycles) ? MAX_HL : dirSetupCycles;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int PW     = pendingBits + 1;

    localparam logic [TW-1:0] HIGH_LOAD  = TW'(pulseHighCycles - 1);
    localparam logic [TW-1:0] LOW_LOAD   = TW'(pulseLowCycles - 1);
    localparam logic [TW-1:0] SETUP_LOAD = TW'(dirSetupCycles - 1);

    localparam logic signed [PW-1:0] P_MAX = {2'b00, {(pendingBits-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = -P_MAX;

    logic [1:0]                    r_state;
    logic [TW-1:0]                 r_timer;
    logic                          r_step;
    logic                          r_dir;
    logic                          r_overflow;
    logic signed [pendingBits-1:0] r_pending;

    logic                 w_nonzero;
    logic                 w_sign_match;
    logic                 w_start;
    logic signed [PW-1:0] w_pend_ext;
    logic signed [PW-1:0] w_delta_ext;
    logic signed [PW-1:0] w_issue_adj;
    logic signed [PW-1:0] w_sum;
    logic                 w_sat_hi;
    logic                 w_sat_lo;

    // dir=1 owns positive pending, dir=0 owns negative pending.
    assign w_nonzero    = (r_pending != '0);
    assign w_sign_match = w_nonzero && (r_pending[pendingBits-1] != r_dir);

    always_comb begin
        w_start = 1'b0;
        case (r_state)
            S_IDLE:      w_start = enable && w_sign_match;
            S_DIR_SETUP: w_start = (r_timer == '0) && w_sign_match;
            S_PULSE_LOW: w_start = (r_timer == '0) && enable && w_sign_match;
            default:     w_start = 1'b0;
        endcase
    end

    assign w_pend_ext  = {r_pending[pendingBits-1], r_pending};
    assign w_delta_ext = delta_valid ? {{(PW-deltaBits){delta_steps[deltaBits-1]}}, delta_steps} : '0;
    assign w_issue_adj = !w_start ? '0 : (r_dir ? {PW{1'b1}} : PW'(1));
    assign w_sum       = w_pend_ext + w_delta_ext + w_issue_adj;
    assign w_sat_hi    = (w_sum > P_MAX);
    assign w_sat_lo    = (w_sum < P_MIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (flush) begin
                r_pending <= '0;
            end else if (w_sat_hi) begin
                r_pending  <= P_MAX[pendingBits-1:0];
                r_overflow <= 1'b1;
            end else if (w_sat_lo) begin
                r_pending  <= P_MIN[pendingBits-1:0];
                r_overflow <= 1'b1;
            end else begin
                r_pending <= w_sum[pendingBits-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_PULSE_HIGH;
                        r_step  <= 1'b1;
                        r_timer <= HIGH_LOAD;
                    end else if (enable && w_nonzero) begin
                        r_dir   <= ~r_dir;
                        r_state <= S_DIR_SETUP;
                        r_timer <= SETUP_LOAD;
                    end
                end
                S_DIR_SETUP: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_start) begin
                        r_state <= S_PULSE_HIGH;
                        r_step  <= 1'b1;
                        r_timer <= HIGH_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PULSE_HIGH: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else begin
                        r_state <= S_PULSE_LOW;
                        r_step  <= 1'b0;
                        r_timer <= LOW_LOAD;
                    end
                end
                default: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_start) begin
                        r_state <= S_PULSE_HIGH;
                        r_step  <= 1'b1;
                        r_timer <= HIGH_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef STEP_POSITION_COUNTER_EN
    logic [31:0] r_position;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_position <= '0;
        end else if (w_start) begin
            r_position <= r_position + (r_dir ? 32'd1 : 32'hFFFF_FFFF);
        end
    end

    assign position = r_position;
`endif

    assign step     = r_step;
    assign dir      = r_dir;
    assign busy     = (r_state != S_IDLE);
    assign overflow = r_overflow;
    assign pending  = r_pending;

endmodule

// File: tb/tb_step_pulse_sequencer.sv
// tb/tb_step_pulse_sequencer.sv - directed self-checking bench for step_pulse_sequencer
module tb_step_pulse_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        delta_valid;
    logic [15:0] delta_steps;
    logic        flush;
    logic        step;
    logic        dir;
    logic        busy;
    logic        overflow;
    logic [19:0] pending;
`ifdef STEP_POSITION_COUNTER_EN
    logic [31:0] position;
`endif

    int n_pass  = 0;
    int n_total = 0;

    step_pulse_sequencer #(
        .deltaBits(16),
        .pendingBits(20),
        .pulseHighCycles(4),
        .pulseLowCycles(4),
        .dirSetupCycles(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .delta_valid(delta_valid),
        .delta_steps(delta_steps),
        .flush(flush),
        .step(step),
        .dir(dir),
        .busy(busy),
        .overflow(overflow),
        .pending(pending)
`ifdef STEP_POSITION_COUNTER_EN
        ,
        .position(position)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tickn(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic strobe(input logic [15:0] value);
        delta_valid = 1'b1;
        delta_steps = value;
        tick();
        delta_valid = 1'b0;
        delta_steps = '0;
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        tick();
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        chk(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        delta_valid = 1'b0;
        delta_steps = '0;
        flush       = 1'b0;
        tickn(2);
        chk("rst_step", {31'b0, step}, 32'd0);
        chk("rst_dir", {31'b0, dir}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_pending", {12'b0, pending}, 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // +3 from dir=0: reversal, 2-cycle setup, three pulses with period 8
        strobe(16'd3);
        chk("r34_pend_n", {12'b0, pending}, 32'd3);
        chk("r34_dir_n", {31'b0, dir}, 32'd0);
        tick();
        chk("r34_dir_n1", {31'b0, dir}, 32'd1);
        chk("r34_busy_n1", {31'b0, busy}, 32'd1);
        tick();
        chk("r34_step_n2", {31'b0, step}, 32'd0);
        tick();
        chk("r34_step_n3", {31'b0, step}, 32'd1);
        chk("r34_pend_n3", {12'b0, pending}, 32'd2);
        tickn(3);
        chk("r34_step_n6", {31'b0, step}, 32'd1);
        tick();
        chk("r34_step_n7", {31'b0, step}, 32'd0);
        tickn(4);
        chk("r34_step_n11", {31'b0, step}, 32'd1);
        chk("r34_pend_n11", {12'b0, pending}, 32'd1);
        tickn(8);
        chk("r34_step_n19", {31'b0, step}, 32'd1);
        chk("r34_pend_n19", {12'b0, pending}, 32'd0);
        tickn(7);
        chk("r34_busy_n26", {31'b0, busy}, 32'd1);
        tick();
        chk("r34_busy_n27", {31'b0, busy}, 32'd0);

        // delta on the same edge a pulse starts
        strobe(16'd1);
        chk("r37_pend_m", {12'b0, pending}, 32'd1);
        strobe(16'd1);
        chk("r37_step_m1", {31'b0, step}, 32'd1);
        chk("r37_pend_m1", {12'b0, pending}, 32'd1);
        tickn(7);
        chk("r37_step_m8", {31'b0, step}, 32'd0);
        tick();
        chk("r37_step_m9", {31'b0, step}, 32'd1);
        chk("r37_pend_m9", {12'b0, pending}, 32'd0);
        tickn(8);
        chk("r37_busy_m17", {31'b0, busy}, 32'd0);

        // reversal during a pulse
        strobe(16'd2);
        chk("r35_pend_a", {12'b0, pending}, 32'd2);
        tick();
        chk("r35_step_a1", {31'b0, step}, 32'd1);
        strobe(16'hFFFB);
        chk("r35_pend_a2", {12'b0, pending}, 32'h000F_FFFC);
        chk("r35_dir_a2", {31'b0, dir}, 32'd1);
        tickn(3);
        chk("r35_step_a5", {31'b0, step}, 32'd0);
        chk("r35_dir_a5", {31'b0, dir}, 32'd1);
        tickn(4);
        chk("r35_busy_a9", {31'b0, busy}, 32'd0);
        tick();
        chk("r35_dir_a10", {31'b0, dir}, 32'd0);
        tick();
        chk("r35_step_a11", {31'b0, step}, 32'd0);
        tick();
        chk("r35_step_a12", {31'b0, step}, 32'd1);
        chk("r35_pend_a12", {12'b0, pending}, 32'h000F_FFFD);
        tickn(24);
        chk("r35_step_a36", {31'b0, step}, 32'd1);
        chk("r35_pend_a36", {12'b0, pending}, 32'd0);
        tickn(8);
        chk("r35_busy_a44", {31'b0, busy}, 32'd0);

        // saturation with enable low
        enable = 1'b0;
        for (int i = 0; i < 16; i++) strobe(16'h7FFF);
        chk("r36_pend_16", {12'b0, pending}, 32'h0007_FFF0);
        chk("r36_ovf_16", {31'b0, overflow}, 32'd0);
        strobe(16'h7FFF);
        chk("r36_pend_17", {12'b0, pending}, 32'h0007_FFFF);
        chk("r36_ovf_17", {31'b0, overflow}, 32'd1);
        chk("r36_step_17", {31'b0, step}, 32'd0);
        tick();
        chk("r36_ovf_after", {31'b0, overflow}, 32'd0);
        chk("r36_pend_after", {12'b0, pending}, 32'h0007_FFFF);
        chk("r36_busy", {31'b0, busy}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_pend", {12'b0, pending}, 32'd0);

        // asynchronous reset inside PULSE_HIGH
        enable = 1'b1;
        strobe(16'hFFFD);
        chk("r38_pend_b", {12'b0, pending}, 32'h000F_FFFD);
        tick();
        chk("r38_step_b1", {31'b0, step}, 32'd1);
        chk("r38_pend_b1", {12'b0, pending}, 32'h000F_FFFE);
        tick();
        chk("r38_step_b2", {31'b0, step}, 32'd1);
        reset = 1'b1;
        #1;
        chk("r38_async_step", {31'b0, step}, 32'd0);
        chk("r38_async_pend", {12'b0, pending}, 32'd0);
        chk("r38_async_busy", {31'b0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("r31_idle_busy", {31'b0, busy}, 32'd0);
        chk("r31_idle_step", {31'b0, step}, 32'd0);

`ifdef STEP_POSITION_COUNTER_EN
        chk("r39_pos_rst", position, 32'd0);
        strobe(16'd3);
        wait_idle("r39_idle_up");
        strobe(16'hFFFE);
        wait_idle("r39_idle_down");
        chk("r39_position", position, 32'd1);
`else
        strobe(16'd1);
        wait_idle("end_idle");
        chk("end_pend", {12'b0, pending}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
